// File: rtl/tcdm_ecc_pkg.sv
// Shared types and SECDED (39/32) code definition for the TCDM ECC scrubber.
// The check matrix is a Hsiao-style code: every data column is a distinct
// weight-3 vector over the 7 check bits, check bits are unit vectors.
package tcdm_ecc_pkg;

  localparam int unsigned ECC_DATA_W = 32;
  localparam int unsigned ECC_CODE_W = 39;
  localparam int unsigned ECC_CHK_W  = ECC_CODE_W - ECC_DATA_W;

  typedef logic [1:0] ecc_err_t;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    WRITEBACK
  } scrub_state_e;

  // Column of the check matrix for each data bit (first 32 weight-3 values).
  localparam logic [ECC_CHK_W-1:0] SECDED_COL [ECC_DATA_W] = '{
    7'd7,  7'd11, 7'd13, 7'd14, 7'd19, 7'd21, 7'd22, 7'd25,
    7'd26, 7'd28, 7'd35, 7'd37, 7'd38, 7'd41, 7'd42, 7'd44,
    7'd49, 7'd50, 7'd52, 7'd56, 7'd67, 7'd69, 7'd70, 7'd73,
    7'd74, 7'd76, 7'd81, 7'd82, 7'd84, 7'd88, 7'd97, 7'd98
  };

  // Check bits of a 32-bit data word.
  function automatic logic [ECC_CHK_W-1:0] secded_checks(input logic [ECC_DATA_W-1:0] data);
    logic [ECC_CHK_W-1:0] chk;
    chk = '0;
    for (int unsigned i = 0; i < ECC_DATA_W; i++) begin
      chk = chk ^ (SECDED_COL[i] & {ECC_CHK_W{data[i]}});
    end
    return chk;
  endfunction

endpackage

// File: rtl/tcdm_ecc_scrubber_cnt.sv
// Saturating event counter for the scrubber error statistics.
module ecc_sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] r_cnt;

  // Count events, sticking at all-ones.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (inc_i && (r_cnt != '1)) begin
      r_cnt <= r_cnt + WIDTH'(1);
    end
  end

  assign cnt_o = r_cnt;

endmodule

// File: rtl/tcdm_ecc_scrubber_secded.sv
// SECDED 39/32 encoder and decoder used by the scrubber.
// Codeword layout: [38:32] check bits, [31:0] data.
module prim_secded_39_32_enc
  import tcdm_ecc_pkg::*;
(
  input  logic [ECC_DATA_W-1:0] data_i,
  output logic [ECC_CODE_W-1:0] data_o
);

  // Append the check bits to the raw data.
  always_comb begin
    data_o = {secded_checks(data_i), data_i};
  end

endmodule

module prim_secded_39_32_dec
  import tcdm_ecc_pkg::*;
(
  input  logic [ECC_CODE_W-1:0] data_i,
  output logic [ECC_DATA_W-1:0] data_o,
  output ecc_err_t              err_o
);

  logic [ECC_CHK_W-1:0] w_syn;
  logic                 w_hit;

  // Syndrome decode: unit vector = check-bit error, data column = data-bit
  // error (corrected), anything else nonzero = uncorrectable.
  always_comb begin
    w_syn  = data_i[ECC_CODE_W-1:ECC_DATA_W] ^ secded_checks(data_i[ECC_DATA_W-1:0]);
    data_o = data_i[ECC_DATA_W-1:0];
    err_o  = 2'b00;
    w_hit  = 1'b0;
    if (w_syn != '0) begin
      if ($onehot(w_syn)) begin
        err_o = 2'b01;
      end else begin
        for (int unsigned i = 0; i < ECC_DATA_W; i++) begin
          if (w_syn == SECDED_COL[i]) begin
            data_o[i] = ~data_i[i];
            w_hit     = 1'b1;
          end
        end
        err_o = w_hit ? 2'b01 : 2'b10;
      end
    end
  end

endmodule

// File: rtl/tcdm_ecc_scrubber.sv
// TCDM bank front-end with background SECDED scrubbing.
// Interconnect traffic has priority; the scrubber reads every word in turn,
// and rewrites single-bit-error words with their corrected encoding.
// Optional error counters: define SCRUBBER_ERR_CNT_EN.
module tcdm_ecc_scrubber
  import tcdm_ecc_pkg::*;
#(
  parameter int unsigned BANK_SIZE      = 256,
  parameter int unsigned SCRUB_INTERVAL = 64,
  parameter int unsigned STALL_MAX      = 16,
  parameter int unsigned CNT_WIDTH      = 16,
  localparam int unsigned AW            = $clog2(BANK_SIZE)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  scrub_en_i,
  input  logic                  intc_req_i,
  input  logic [AW-1:0]         intc_add_i,
  input  logic                  intc_wen_i,
  input  logic [ECC_CODE_W-1:0] intc_wdata_i,
  input  logic [3:0]            intc_be_i,
  output logic                  intc_gnt_o,
  output logic                  intc_rvalid_o,
  output logic [ECC_CODE_W-1:0] intc_rdata_o,
  output logic                  bank_req_o,
  output logic [AW-1:0]         bank_add_o,
  output logic                  bank_wen_o,
  output logic [ECC_CODE_W-1:0] bank_wdata_o,
  output logic [3:0]            bank_be_o,
  input  logic [ECC_CODE_W-1:0] bank_rdata_i,
  output logic                  sweep_done_o,
  output logic                  corr_o,
  output logic                  uncorr_o,
  output logic [CNT_WIDTH-1:0]  corr_cnt_o,
  output logic [CNT_WIDTH-1:0]  uncorr_cnt_o
);

  localparam int unsigned IW = (SCRUB_INTERVAL > 0) ? $clog2(SCRUB_INTERVAL + 1) : 1;
  localparam int unsigned SW = (STALL_MAX > 0) ? $clog2(STALL_MAX + 1) : 1;

  scrub_state_e          r_state;
  logic [AW-1:0]         r_scrub_addr;
  logic [IW-1:0]         r_interval;
  logic [SW-1:0]         r_stall;
  logic [ECC_CODE_W-1:0] r_wb_data;
  logic                  r_rvalid;
  logic                  r_corr;
  logic                  r_uncorr;
  logic                  r_sweep_done;

  logic                  w_force_wb;
  logic                  w_gnt;
  logic                  w_collision;
  logic                  w_scrub_rd;
  logic                  w_wb_go;
  logic                  w_advance;
  logic [ECC_DATA_W-1:0] w_dec_data;
  ecc_err_t              w_dec_err;
  logic [ECC_CODE_W-1:0] w_enc_data;

  prim_secded_39_32_dec u_dec (
    .data_i (bank_rdata_i),
    .data_o (w_dec_data),
    .err_o  (w_dec_err)
  );

  prim_secded_39_32_enc u_enc (
    .data_i (w_dec_data),
    .data_o (w_enc_data)
  );

  // Arbitration: interconnect first, scrub read/write-back in free cycles.
  // Requests are masked while reset is asserted so the bank sees nothing.
  always_comb begin
    w_force_wb  = (r_state == WRITEBACK) && (r_stall == SW'(STALL_MAX));
    w_gnt       = rst_ni && intc_req_i && !w_force_wb;
    w_collision = w_gnt && !intc_wen_i && (intc_add_i == r_scrub_addr) && (r_state != IDLE);
    w_scrub_rd  = rst_ni && (r_state == IDLE) && scrub_en_i && (r_interval == '0) && !intc_req_i;
    w_wb_go     = rst_ni && (r_state == WRITEBACK) && (!intc_req_i || w_force_wb);
    w_advance   = 1'b0;
    if (r_state == CHECK) begin
      w_advance = !w_dec_err[0] || w_dec_err[1] || w_collision;
    end else if (r_state == WRITEBACK) begin
      w_advance = w_wb_go || w_collision;
    end
  end

  // Bank port multiplexer.
  always_comb begin
    bank_req_o   = 1'b0;
    bank_add_o   = '0;
    bank_wen_o   = 1'b0;
    bank_wdata_o = '0;
    bank_be_o    = '0;
    if (w_gnt) begin
      bank_req_o   = 1'b1;
      bank_add_o   = intc_add_i;
      bank_wen_o   = intc_wen_i;
      bank_wdata_o = intc_wdata_i;
      bank_be_o    = intc_be_i;
    end else if (w_scrub_rd) begin
      bank_req_o   = 1'b1;
      bank_add_o   = r_scrub_addr;
      bank_wen_o   = 1'b1;
      bank_be_o    = 4'hF;
    end else if (w_wb_go) begin
      bank_req_o   = 1'b1;
      bank_add_o   = r_scrub_addr;
      bank_wen_o   = 1'b0;
      bank_wdata_o = r_wb_data;
      bank_be_o    = 4'hF;
    end
  end

  // Scrub FSM, sweep address, interval/stall counters and event pulses.
  // A granted interconnect write to the scrub word in CHECK/WRITEBACK skips
  // the write-back so the fresh data survives.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= IDLE;
      r_scrub_addr <= '0;
      r_interval   <= IW'(SCRUB_INTERVAL);
      r_stall      <= '0;
      r_wb_data    <= '0;
      r_rvalid     <= 1'b0;
      r_corr       <= 1'b0;
      r_uncorr     <= 1'b0;
      r_sweep_done <= 1'b0;
    end else begin
      r_rvalid     <= w_gnt && intc_wen_i;
      r_corr       <= 1'b0;
      r_uncorr     <= 1'b0;
      r_sweep_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (scrub_en_i) begin
            if (r_interval != '0) begin
              r_interval <= r_interval - IW'(1);
            end else if (w_scrub_rd) begin
              r_state <= CHECK;
            end
          end
        end
        CHECK: begin
          if (w_dec_err[1]) begin
            r_uncorr <= 1'b1;
          end else if (w_dec_err[0]) begin
            r_corr <= 1'b1;
            if (!w_collision) begin
              r_wb_data <= w_enc_data;
              r_stall   <= '0;
              r_state   <= WRITEBACK;
            end
          end
        end
        WRITEBACK: begin
          if (!w_advance) begin
            r_stall <= r_stall + SW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
      if (w_advance) begin
        r_state      <= IDLE;
        r_stall      <= '0;
        r_scrub_addr <= r_scrub_addr + AW'(1);
        r_interval   <= IW'(SCRUB_INTERVAL);
        r_sweep_done <= (r_scrub_addr == AW'(BANK_SIZE - 1));
      end
    end
  end

`ifdef SCRUBBER_ERR_CNT_EN
  ecc_sat_counter #(.WIDTH(CNT_WIDTH)) u_corr_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (r_corr),
    .cnt_o  (corr_cnt_o)
  );

  ecc_sat_counter #(.WIDTH(CNT_WIDTH)) u_uncorr_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (r_uncorr),
    .cnt_o  (uncorr_cnt_o)
  );
`else
  assign corr_cnt_o   = '0;
  assign uncorr_cnt_o = '0;
`endif

  assign intc_gnt_o    = w_gnt;
  assign intc_rvalid_o = r_rvalid;
  assign intc_rdata_o  = bank_rdata_i;
  assign sweep_done_o  = r_sweep_done;
  assign corr_o        = r_corr;
  assign uncorr_o      = r_uncorr;

endmodule

// File: tb/tb_tcdm_ecc_scrubber.sv
// Directed bench for tcdm_ecc_scrubber with an 8-word behavioural bank.
// All-zero data encodes to the all-zero codeword, so injected errors are
// plain bit patterns and corrected words must come back as zero.
module tb_tcdm_ecc_scrubber;

  localparam int unsigned BS = 8;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        scrub_en_i;
  logic        intc_req_i;
  logic [2:0]  intc_add_i;
  logic        intc_wen_i;
  logic [38:0] intc_wdata_i;
  logic [3:0]  intc_be_i;
  logic        intc_gnt_o;
  logic        intc_rvalid_o;
  logic [38:0] intc_rdata_o;
  logic        bank_req_o;
  logic [2:0]  bank_add_o;
  logic        bank_wen_o;
  logic [38:0] bank_wdata_o;
  logic [3:0]  bank_be_o;
  logic [38:0] bank_rdata = '0;
  logic        sweep_done_o;
  logic        corr_o;
  logic        uncorr_o;
  logic [15:0] corr_cnt_o;
  logic [15:0] uncorr_cnt_o;

  always #5 clk = ~clk;

  tcdm_ecc_scrubber #(
    .BANK_SIZE      (BS),
    .SCRUB_INTERVAL (0),
    .STALL_MAX      (16),
    .CNT_WIDTH      (16)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .scrub_en_i    (scrub_en_i),
    .intc_req_i    (intc_req_i),
    .intc_add_i    (intc_add_i),
    .intc_wen_i    (intc_wen_i),
    .intc_wdata_i  (intc_wdata_i),
    .intc_be_i     (intc_be_i),
    .intc_gnt_o    (intc_gnt_o),
    .intc_rvalid_o (intc_rvalid_o),
    .intc_rdata_o  (intc_rdata_o),
    .bank_req_o    (bank_req_o),
    .bank_add_o    (bank_add_o),
    .bank_wen_o    (bank_wen_o),
    .bank_wdata_o  (bank_wdata_o),
    .bank_be_o     (bank_be_o),
    .bank_rdata_i  (bank_rdata),
    .sweep_done_o  (sweep_done_o),
    .corr_o        (corr_o),
    .uncorr_o      (uncorr_o),
    .corr_cnt_o    (corr_cnt_o),
    .uncorr_cnt_o  (uncorr_cnt_o)
  );

  logic [38:0] mem [BS];

  always @(posedge clk) begin
    if (bank_req_o) begin
      if (bank_wen_o) bank_rdata <= mem[bank_add_o];
      else            mem[bank_add_o] <= bank_wdata_o;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit scrub_rd();
    return bank_req_o && bank_wen_o && !intc_gnt_o;
  endfunction

  function automatic bit scrub_wr();
    return bank_req_o && !bank_wen_o && !intc_gnt_o;
  endfunction

  task automatic apply_reset(input int unsigned idx, input logic [38:0] val);
    rst_ni       = 1'b0;
    scrub_en_i   = 1'b0;
    intc_req_i   = 1'b0;
    intc_add_i   = '0;
    intc_wen_i   = 1'b0;
    intc_wdata_i = '0;
    intc_be_i    = '0;
    for (int i = 0; i < BS; i++) mem[i] <= '0;
    mem[idx] <= val;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
  endtask

  task automatic wait_scrub_read(input logic [2:0] a, output bit found);
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk);
      if (scrub_rd() && bank_add_o == a) found = 1'b1;
    end
  endtask

  typedef struct {
    int unsigned idx;
    logic [38:0] val;
    int unsigned exp_corr;
    int unsigned exp_uncorr;
    int unsigned exp_wr;
    logic [38:0] exp_final;
  } vec_t;

  vec_t vecs [7];
  int   reads, writes, ncorr, nuncorr, others;
  bit   seen, found;
  int   low_cnt, low_idx, wb_ok;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{0, 39'h0,            0, 0, 0, 39'h0};
    vecs[1] = '{3, 39'h1,            1, 0, 1, 39'h0};
    vecs[2] = '{5, 39'h3,            0, 1, 0, 39'h3};
    vecs[3] = '{6, 39'h08_0000_0000, 1, 0, 1, 39'h0};
    vecs[4] = '{7, 39'h40_8000_0000, 0, 1, 0, 39'h40_8000_0000};
    vecs[5] = '{1, 39'h7F_0000_0000, 0, 1, 0, 39'h7F_0000_0000};
    vecs[6] = '{2, 39'h00_0001_0000, 1, 0, 1, 39'h0};

    // Reset values with scrubbing requested during reset.
    rst_ni = 1'b0; scrub_en_i = 1'b1; intc_req_i = 1'b0; intc_add_i = '0;
    intc_wen_i = 1'b0; intc_wdata_i = '0; intc_be_i = '0;
    #12;
    chk("rst_gnt", intc_gnt_o, 0);
    chk("rst_rvalid", intc_rvalid_o, 0);
    chk("rst_bank_req", bank_req_o, 0);
    chk("rst_bank_add", bank_add_o, 0);
    chk("rst_bank_wdata", bank_wdata_o, 0);
    chk("rst_bank_be", bank_be_o, 0);
    chk("rst_sweep", sweep_done_o, 0);
    chk("rst_corr", corr_o, 0);
    chk("rst_uncorr", uncorr_o, 0);
    chk("rst_corr_cnt", corr_cnt_o, 0);
    chk("rst_uncorr_cnt", uncorr_cnt_o, 0);

    // One full sweep per vector with a single injected word.
    for (int v = 0; v < 7; v++) begin
      apply_reset(vecs[v].idx, vecs[v].val);
      @(posedge clk); #1;
      scrub_en_i = 1'b1;
      reads = 0; writes = 0; ncorr = 0; nuncorr = 0; seen = 1'b0;
      for (int k = 0; k < 200 && !seen; k++) begin
        @(negedge clk);
        if (sweep_done_o) seen = 1'b1;
        else if (scrub_rd()) reads++;
        if (scrub_wr()) writes++;
        ncorr   += int'(corr_o);
        nuncorr += int'(uncorr_o);
      end
      scrub_en_i = 1'b0;
      repeat (5) begin
        @(negedge clk);
        if (scrub_rd()) reads++;
        if (scrub_wr()) writes++;
        ncorr   += int'(corr_o);
        nuncorr += int'(uncorr_o);
      end
      others = 0;
      for (int i = 0; i < BS; i++) if (i != int'(vecs[v].idx) && mem[i] != '0) others++;
      chk($sformatf("v%0d_sweep_seen", v), seen, 1);
      chk($sformatf("v%0d_reads", v), reads, 8);
      chk($sformatf("v%0d_writes", v), writes, vecs[v].exp_wr);
      chk($sformatf("v%0d_corr", v), ncorr, vecs[v].exp_corr);
      chk($sformatf("v%0d_uncorr", v), nuncorr, vecs[v].exp_uncorr);
      chk($sformatf("v%0d_word", v), mem[vecs[v].idx], vecs[v].exp_final);
      chk($sformatf("v%0d_others", v), others, 0);
`ifdef SCRUBBER_ERR_CNT_EN
      chk($sformatf("v%0d_corr_cnt", v), corr_cnt_o, vecs[v].exp_corr);
      chk($sformatf("v%0d_uncorr_cnt", v), uncorr_cnt_o, vecs[v].exp_uncorr);
`else
      chk($sformatf("v%0d_corr_cnt", v), corr_cnt_o, 0);
      chk($sformatf("v%0d_uncorr_cnt", v), uncorr_cnt_o, 0);
`endif
    end

    // Write-back starved by interconnect reads until forced after 16 stalls.
    apply_reset(2, 39'h1);
    @(posedge clk); #1;
    scrub_en_i = 1'b1;
    wait_scrub_read(3'd2, found);
    chk("stall_read_seen", found, 1);
    @(posedge clk); #1;
    intc_req_i = 1'b1; intc_wen_i = 1'b1; intc_add_i = 3'd0;
    low_cnt = 0; low_idx = -1; wb_ok = 0; ncorr = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!intc_gnt_o) begin
        low_cnt++;
        low_idx = k;
        if (bank_req_o && !bank_wen_o && bank_add_o == 3'd2 && bank_wdata_o == 39'h0 && bank_be_o == 4'hF)
          wb_ok++;
      end
      ncorr += int'(corr_o);
      @(posedge clk); #1;
    end
    intc_req_i = 1'b0;
    chk("stall_gnt_low_cycles", low_cnt, 1);
    chk("stall_gnt_low_index", low_idx, 17);
    chk("stall_forced_wb", wb_ok, 1);
    chk("stall_corr", ncorr, 1);
    chk("stall_word2", mem[2], 39'h0);

    // Interconnect write to the scrub word during WRITEBACK cancels it.
    apply_reset(4, 39'h1);
    @(posedge clk); #1;
    scrub_en_i = 1'b1;
    wait_scrub_read(3'd4, found);
    chk("coll_read_seen", found, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    intc_req_i = 1'b1; intc_wen_i = 1'b0; intc_add_i = 3'd4;
    intc_wdata_i = 39'h0ABCD; intc_be_i = 4'hF;
    @(negedge clk);
    chk("coll_gnt", intc_gnt_o, 1);
    chk("coll_bank_wdata", bank_wdata_o, 39'h0ABCD);
    chk("coll_corr", corr_o, 1);
    @(posedge clk); #1;
    intc_req_i = 1'b0; scrub_en_i = 1'b0;
    writes = 0;
    repeat (3) begin
      @(negedge clk);
      if (scrub_wr()) writes++;
    end
    chk("coll_no_wb", writes, 0);
    chk("coll_word4", mem[4], 39'h0ABCD);
    @(posedge clk); #1;
    intc_req_i = 1'b1; intc_wen_i = 1'b1; intc_add_i = 3'd4;
    @(negedge clk);
    chk("coll_rd_gnt", intc_gnt_o, 1);
    @(posedge clk); #1;
    intc_req_i = 1'b0;
    @(negedge clk);
    chk("coll_rvalid", intc_rvalid_o, 1);
    chk("coll_rdata", intc_rdata_o, 39'h0ABCD);

    // Reset asserted while a write-back is pending.
    apply_reset(3, 39'h1);
    @(posedge clk); #1;
    scrub_en_i = 1'b1;
    wait_scrub_read(3'd3, found);
    chk("wbrst_read_seen", found, 1);
    @(posedge clk); #1;
    intc_req_i = 1'b1; intc_wen_i = 1'b1; intc_add_i = 3'd0;
    @(posedge clk); #1;
    chk("wbrst_pre_corr", corr_o, 1);
    rst_ni = 1'b0; intc_req_i = 1'b0;
    #1;
    chk("wbrst_corr", corr_o, 0);
    chk("wbrst_rvalid", intc_rvalid_o, 0);
    chk("wbrst_bank_req", bank_req_o, 0);
    chk("wbrst_gnt", intc_gnt_o, 0);
    chk("wbrst_sweep", sweep_done_o, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    #1;
    chk("wbrst_restart_req", bank_req_o, 1);
    chk("wbrst_restart_add", bank_add_o, 0);
    chk("wbrst_restart_wen", bank_wen_o, 1);
    writes = 0;
    repeat (5) begin
      @(negedge clk);
      if (scrub_wr()) writes++;
    end
    chk("wbrst_no_stale_wr", writes, 0);
    chk("wbrst_word3", mem[3], 39'h1);
    scrub_en_i = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
